alu_share_scheduler: RTL and testbench

//  Shares one ALU instance among NUM_REQ requesters: execute stage, branch compare, address generation.

---
 rtl/alu_share_scheduler_pkg.sv | 45 ++++
 rtl/alu_share_scheduler_rr_arbiter.sv | 41 ++++
 rtl/alu_share_scheduler.sv | 116 +++++++++++
 tb/tb_alu_share_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_scheduler_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : ALU control encodings and legality helper for the shared ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0111,
        ALU_EQ   = 4'b1001,
        ALU_SLL  = 4'b1010,
        ALU_NE   = 4'b1011,
        ALU_SRL  = 4'b1100,
        ALU_SGE  = 4'b1101,
        ALU_SRA  = 4'b1110
    } alu_ctrl_t;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic alu_ctrl_legal(input logic [ALU_CTRL_W-1:0] code);
        logic legal;
        case (code)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
            ALU_EQ, ALU_SLL, ALU_NE, ALU_SRL, ALU_SGE, ALU_SRA: legal = 1'b1;
            default:                                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_share_scheduler_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker; first request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                idx = (int'(ptr) + i) % N;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_idx  = IW'(idx);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_share_scheduler.sv
// ============================================================================
// Module   : alu_share_scheduler
// Purpose  : Round-robin sharing of one ALU with a single-entry response slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_scheduler
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int XLEN    = 32,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0][XLEN-1:0]        req_a,
    input  logic [NUM_REQ-1:0][XLEN-1:0]        req_b,
    input  logic [NUM_REQ-1:0][ALU_CTRL_W-1:0]  req_ctrl,
    output logic [XLEN-1:0]                     alu_src_a,
    output logic [XLEN-1:0]                     alu_src_b,
    output logic [ALU_CTRL_W-1:0]               alu_ctrl,
    input  logic [XLEN-1:0]                     alu_result,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [XLEN-1:0]                     rsp_result,
    output logic [ID_W-1:0]                     rsp_id,
    output logic                                rsp_err
);

    slot_state_t             state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [XLEN-1:0]         rsp_result_q, rsp_result_d;
    logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    can_accept;
    logic                    xfer;
    logic                    illegal;
    logic [NUM_REQ-1:0]      gnt;
    logic [ID_W-1:0]         gnt_idx;
    logic [ALU_CTRL_W-1:0]   gnt_ctrl;

    assign can_accept = !flush && ((state_q == SLOT_EMPTY) || rsp_ready);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .en      (can_accept),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;
    assign gnt_ctrl  = req_ctrl[gnt_idx];
    assign illegal   = !alu_ctrl_legal(gnt_ctrl);

    // Idle ALU inputs park at zero/add so the shared ALU does not toggle.
    always_comb begin
        alu_src_a = '0;
        alu_src_b = '0;
        alu_ctrl  = ALU_ADD;
        if (xfer) begin
            alu_src_a = req_a[gnt_idx];
            alu_src_b = req_b[gnt_idx];
            alu_ctrl  = illegal ? ALU_ADD : gnt_ctrl;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        if (flush) begin
            state_d = SLOT_EMPTY;
        end else if (xfer) begin
            state_d      = SLOT_FULL;
            rsp_result_d = illegal ? '0 : alu_result;
            rsp_id_d     = gnt_idx;
            rsp_err_d    = illegal;
            rr_ptr_d     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if ((state_q == SLOT_FULL) && rsp_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SLOT_EMPTY;
            rr_ptr_q     <= '0;
            rsp_result_q <= '0;
            rsp_id_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = (state_q == SLOT_FULL);
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_scheduler.sv
// ============================================================================
// Module   : tb_alu_share_scheduler
// Purpose  : Directed self-checking bench with a behavioural ALU attached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_scheduler;

    localparam int C_NUM_REQ = 2;
    localparam int C_XLEN    = 32;

    logic                                  clk;
    logic                                  rst_n;
    logic                                  flush;
    logic [C_NUM_REQ-1:0]                  req_valid;
    logic [C_NUM_REQ-1:0]                  req_ready;
    logic [C_NUM_REQ-1:0][C_XLEN-1:0]      req_a;
    logic [C_NUM_REQ-1:0][C_XLEN-1:0]      req_b;
    logic [C_NUM_REQ-1:0][3:0]             req_ctrl;
    logic [C_XLEN-1:0]                     alu_src_a;
    logic [C_XLEN-1:0]                     alu_src_b;
    logic [3:0]                            alu_ctrl;
    logic [C_XLEN-1:0]                     alu_result;
    logic                                  rsp_valid;
    logic                                  rsp_ready;
    logic [C_XLEN-1:0]                     rsp_result;
    logic [0:0]                            rsp_id;
    logic                                  rsp_err;

    int n_pass;
    int n_total;

    alu_share_scheduler #(.NUM_REQ(C_NUM_REQ), .XLEN(C_XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err)
    );

    // Behavioural stand-in for the external ALU.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_src_a + alu_src_b;
            4'b0001: alu_result = alu_src_a - alu_src_b;
            4'b0010: alu_result = alu_src_a & alu_src_b;
            4'b0011: alu_result = alu_src_a | alu_src_b;
            4'b0100: alu_result = alu_src_a ^ alu_src_b;
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b1;

        #12;
        chk("reset_valid",  {31'd0, rsp_valid}, 32'd0);
        chk("reset_result", rsp_result,         32'd0);
        chk("reset_id",     {31'd0, rsp_id},    32'd0);
        chk("reset_err",    {31'd0, rsp_err},   32'd0);
        chk("idle_src_a",   alu_src_a,          32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single op from r0, 5 - 3
        req_valid   = 2'b01;
        req_a[0]    = 32'd5;
        req_b[0]    = 32'd3;
        req_ctrl[0] = 4'b0001;
        #1;
        chk("t1_ready",  {30'd0, req_ready}, 32'd1);
        chk("t1_src_a",  alu_src_a,          32'd5);
        chk("t1_ctrl",   {28'd0, alu_ctrl},  32'd1);
        tick();
        req_valid = 2'b00;
        chk("t1_valid",  {31'd0, rsp_valid}, 32'd1);
        chk("t1_result", rsp_result,         32'd2);
        chk("t1_id",     {31'd0, rsp_id},    32'd0);
        chk("t1_err",    {31'd0, rsp_err},   32'd0);
        tick();
        chk("t1_drain",  {31'd0, rsp_valid}, 32'd0);

        // 2: contention; pointer sits at 1 after test 1 so grants run 1,0,1,0
        req_a[0] = 32'd10; req_b[0] = 32'd4; req_ctrl[0] = 4'b0000;
        req_a[1] = 32'd6;  req_b[1] = 32'd3; req_ctrl[1] = 4'b0010;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_ready", {30'd0, req_ready}, (k % 2 == 0) ? 32'd2 : 32'd1);
            tick();
            chk("t2_valid",  {31'd0, rsp_valid}, 32'd1);
            chk("t2_id",     {31'd0, rsp_id},    (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_result", rsp_result,         (k % 2 == 0) ? 32'd2 : 32'd14);
        end

        // 3: backpressure holds the r0 response (14)
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_ready",  {30'd0, req_ready}, 32'd0);
            chk("t3_valid",  {31'd0, rsp_valid}, 32'd1);
            chk("t3_id",     {31'd0, rsp_id},    32'd0);
            chk("t3_result", rsp_result,         32'd14);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_release_ready", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        chk("t3_next_id",     {31'd0, rsp_id}, 32'd1);
        chk("t3_next_result", rsp_result,      32'd2);
        tick();

        // 4: illegal code from r1, then a legal xor from r1
        req_a[1] = 32'd7; req_b[1] = 32'd9; req_ctrl[1] = 4'b1111;
        req_valid = 2'b10;
        #1;
        chk("t4_ready", {30'd0, req_ready}, 32'd2);
        chk("t4_ctrl",  {28'd0, alu_ctrl},  32'd0);
        chk("t4_src_a", alu_src_a,          32'd7);
        tick();
        chk("t4_result", rsp_result,       32'd0);
        chk("t4_err",    {31'd0, rsp_err}, 32'd1);
        chk("t4_id",     {31'd0, rsp_id},  32'd1);
        req_ctrl[1] = 4'b0100;
        #1;
        chk("t4_legal_ready", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        chk("t4_legal_result", rsp_result,       32'd14);
        chk("t4_legal_err",    {31'd0, rsp_err}, 32'd0);

        // 5: flush with a pending response and r0 valid
        req_a[0] = 32'd1; req_b[0] = 32'd1; req_ctrl[0] = 4'b0000;
        req_valid = 2'b01;
        flush     = 1'b1;
        #1;
        chk("t5_ready", {30'd0, req_ready}, 32'd0);
        chk("t5_src_a", alu_src_a,          32'd0);
        tick();
        flush = 1'b0;
        chk("t5_valid", {31'd0, rsp_valid}, 32'd0);
        req_valid = 2'b11;
        #1;
        chk("t5_ptr_kept", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        chk("t5_id",     {31'd0, rsp_id}, 32'd0);
        chk("t5_result", rsp_result,      32'd2);

        // 6: async reset while FULL; pointer was 1, must restart at 0
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_async_result", rsp_result,        32'd0);
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("t6_first_ready", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        chk("t6_first_id", {31'd0, rsp_id}, 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
